// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_arb_pkg;

  localparam int W_DEF      = 4;
  localparam int WD_MAX_DEF = 31;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_READY,
    DONE
  } state_e;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester named by ptr.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_idx,
  output logic gnt_vld
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_idx = (req0 && req1) ? ptr : req1;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared shift-add multiplier, with a sticky watchdog.
// Outputs are decoded from registered state so reset clears them immediately.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int WD_MAX = WD_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*W-1:0] result,
  output logic           err,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ready,
  input  logic [2*W-1:0] mul_p
);

  localparam int WDW = $clog2(WD_MAX + 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [2*W-1:0]   result_q, result_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             pick_idx, pick_vld;
  logic             wd_expire;

  rr_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // The counter reaches WD_MAX on the edge that takes this cycle's increment.
  assign wd_expire = (wd_q == WDW'(WD_MAX - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    wd_d     = wd_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    case (state_q)
      IDLE: begin
        if (mul_ready && pick_vld) begin
          owner_d = pick_idx;
          mul_a_d = pick_idx ? a1 : a0;
          mul_b_d = pick_idx ? b1 : b0;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (wd_expire) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else if (!mul_ready) begin
          state_d = WAIT_READY;
        end
      end
      WAIT_READY: begin
        wd_d = wd_q + 1'b1;
        if (mul_ready) begin
          result_d = mul_p;
          state_d  = DONE;
        end else if (wd_expire) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  assign gnt0      = (state_q != IDLE) && !owner_q;
  assign gnt1      = (state_q != IDLE) &&  owner_q;
  assign done0     = (state_q == DONE) && !owner_q;
  assign done1     = (state_q == DONE) &&  owner_q;
  assign mul_start = (state_q == ISSUE);
  assign result    = result_q;
  assign err       = err_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, requester queues, result scoreboard.
module tb_mult_arbiter;

  localparam int W    = 4;
  localparam int WD   = 31;
  localparam int BUSY = 4;

  typedef struct {
    logic           owner;
    logic [2*W-1:0] prod;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           gnt0, gnt1, done0, done1, err, mul_start;
  logic [2*W-1:0] result;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_ready;
  logic [2*W-1:0] mul_p;

  exp_t exp_q[$];
  op_t  ops0[$];
  op_t  ops1[$];
  logic glog[$];
  exp_t e;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   dcnt     = 0;
  int   starts   = 0;
  logic hang     = 1'b0;
  int   mcnt;
  logic [2*W-1:0] mprod;

  mult_arbiter #(.W(W), .WD_MAX(WD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .result    (result),
    .err       (err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_p     (mul_p)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    chk_cnt++;
    if (got === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
  endtask

  // Shared multiplier: busy for BUSY cycles after a start, frozen while hang is set.
  initial begin
    mul_ready = 1'b1;
    mul_p     = '0;
    mprod     = '0;
    mcnt      = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mul_ready <= 1'b1;
        mcnt      <= 0;
      end else if (mul_ready && mul_start) begin
        mul_ready <= 1'b0;
        mprod     <= (2*W)'(mul_a) * (2*W)'(mul_b);
        mcnt      <= BUSY;
      end else if (!mul_ready && !hang) begin
        if (mcnt == 1) begin
          mul_ready <= 1'b1;
          mul_p     <= mprod;
        end
        mcnt <= mcnt - 1;
      end
    end
  end

  // Monitor: logs grants, scores each done pulse, advances the requester queues.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (mul_start) begin
        glog.push_back(gnt1);
        starts++;
      end
      if (done0 || done1) begin
        dcnt++;
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_owner", {31'b0, done1}, {31'b0, e.owner});
          chk("result", {24'b0, result}, {24'b0, e.prod});
          chk("gnt_at_done", {30'b0, gnt1, gnt0}, e.owner ? 32'd2 : 32'd1);
        end
        if (done0 && ops0.size() > 0) begin
          ops0.delete(0);
          if (ops0.size() > 0) begin a0 = ops0[0].a; b0 = ops0[0].b; end
          else req0 = 1'b0;
        end
        if (done1 && ops1.size() > 0) begin
          ops1.delete(0);
          if (ops1.size() > 0) begin a1 = ops1[0].a; b1 = ops1[0].b; end
          else req1 = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    if (who == 0) begin
      ops0.push_back(o);
      if (!req0) begin a0 = a; b0 = b; req0 = 1'b1; end
    end else begin
      ops1.push_back(o);
      if (!req1) begin a1 = a; b1 = b; req1 = 1'b1; end
    end
  endtask

  task automatic expect_res(input logic owner, input logic [2*W-1:0] prod);
    exp_t x;
    x.owner = owner;
    x.prod  = prod;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    hang = 1'b0;
    ops0.delete();
    ops1.delete();
    exp_q.delete();
    glog.delete();
    starts = 0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", {31'b0, exp_q.size() == 0}, 32'd1);
    repeat (2) step();
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (mul_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("start_in_time", {31'b0, mul_start}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("reset_outs", {24'b0, gnt0, gnt1, done0, done1, mul_start, err, 2'b0}, 32'd0);
    chk("reset_result", {24'b0, result}, 32'd0);
    reset_dut();

    // Single requester 0: 3*5.
    issue(0, 4'd3, 4'd5);
    expect_res(1'b0, 8'd15);
    wait_drain(100);
    chk("t1_starts", starts, 32'd1);
    chk("t1_grant0", {31'b0, glog[0]}, 32'd0);
    repeat (3) step();
    chk("t1_result_held", {24'b0, result}, 32'd15);
    chk("t1_gnt_idle", {30'b0, gnt1, gnt0}, 32'd0);

    // Simultaneous requests after reset: pointer 0 favours requester 0.
    reset_dut();
    issue(0, 4'd2, 4'd7);
    issue(1, 4'd15, 4'd15);
    expect_res(1'b0, 8'd14);
    expect_res(1'b1, 8'd225);
    wait_drain(200);
    chk("t2_starts", starts, 32'd2);

    // Requester 0 keeps asking while requester 1 waits: grants alternate.
    reset_dut();
    issue(0, 4'd1, 4'd1);
    issue(0, 4'd2, 4'd2);
    issue(1, 4'd3, 4'd3);
    issue(1, 4'd4, 4'd4);
    expect_res(1'b0, 8'd1);
    expect_res(1'b1, 8'd9);
    expect_res(1'b0, 8'd4);
    expect_res(1'b1, 8'd16);
    wait_drain(400);
    chk("t3_nlog", glog.size(), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("t3_grant_order", {31'b0, glog[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);

    // Multiplier never returns: watchdog fires WD cycles after WAIT_BUSY entry.
    reset_dut();
    hang = 1'b1;
    issue(0, 4'd9, 4'd9);
    expect_res(1'b0, 8'd0);
    wait_start(20);
    for (int k = 1; k <= WD; k++) begin
      step();
      if (k == WD) chk("t4_err_early", {31'b0, err}, 32'd0);
    end
    step();
    chk("t4_err_set", {31'b0, err}, 32'd1);
    chk("t4_done0", {31'b0, done0}, 32'd1);
    chk("t4_result_zero", {24'b0, result}, 32'd0);
    hang = 1'b0;
    step();
    issue(1, 4'd6, 4'd7);
    expect_res(1'b1, 8'd42);
    wait_drain(200);
    chk("t4_err_sticky", {31'b0, err}, 32'd1);
    chk("t4_next_grant", {31'b0, glog[glog.size()-1]}, 32'd1);

    // Reset in WAIT_READY abandons the transaction silently.
    reset_dut();
    issue(0, 4'd5, 4'd5);
    wait_start(20);
    step();
    step();
    #1;
    reset = 1'b1;
    req0 = 1'b0;
    ops0.delete();
    #1;
    chk("t5_outs_zero", {gnt0, gnt1, done0, done1, mul_start, err, mul_a, mul_b, 10'b0}, 32'd0);
    chk("t5_result_zero", {24'b0, result}, 32'd0);
    begin
      int d0;
      d0 = dcnt;
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();
      chk("t5_no_done", dcnt, d0);
    end
    glog.delete();
    issue(1, 4'd7, 4'd3);
    expect_res(1'b1, 8'd21);
    wait_drain(200);
    chk("t5_grant1", (glog.size() == 1) ? {31'b0, glog[0]} : 32'd9, 32'd1);
    chk("t5_err_clear", {31'b0, err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
